fwd_scoreboard_unit: RTL and testbench

// - Parametrised operand-bypass and hazard unit for the EX stage of the rv32i pipeline.
// - Forwards results to NUM_SRC consumer operands from NUM_STG producer stages, where

---
 rtl/fwd_scoreboard_unit.sv | 140 ++++++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// EX-stage operand bypass network with a long-latency pending scoreboard and a WB shadow.
// Optional saturating stall counter is built when FWD_STALL_PERF_EN is defined.
module fwd_scoreboard_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 3,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic [NUM_SRC*AW-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]      src_used,
  input  logic [NUM_SRC*XLEN-1:0] rf_data,
  input  logic [NUM_STG-1:0]      prod_we,
  input  logic [NUM_STG*AW-1:0]   prod_rd,
  input  logic [NUM_STG-1:0]      prod_rdy,
  input  logic [NUM_STG*XLEN-1:0] prod_data,
  input  logic                    ll_issue,
  input  logic [AW-1:0]           ll_rd,
  input  logic                    ll_done,
  input  logic [AW-1:0]           ll_done_rd,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic                    hazard_stall,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0]    pending;
  logic               shadow_v;
  logic [AW-1:0]      shadow_rd;
  logic [XLEN-1:0]    shadow_data;
  logic [NUM_SRC-1:0] src_stall;

  // A producer claims rd whenever prod_we is high; prod_rdy says whether its data is
  // usable yet. A claiming-but-not-ready producer hides every older stage.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [AW-1:0]   addr;
    logic            active;
    logic            match_found;
    logic            match_rdy;
    logic [XLEN-1:0] match_data;
    logic [XLEN-1:0] out_data;
    logic            out_hit;
    logic            out_stall;

    assign addr   = src_addr[i*AW +: AW];
    assign active = src_used[i] && (addr != '0);

    // Scan oldest to youngest so the youngest matching stage is the one left standing.
    always_comb begin
      match_found = 1'b0;
      match_rdy   = 1'b0;
      match_data  = '0;
      for (int s = NUM_STG - 1; s >= 0; s--) begin
        if (prod_we[s] && (prod_rd[s*AW +: AW] != '0) && (prod_rd[s*AW +: AW] == addr)) begin
          match_found = 1'b1;
          match_rdy   = prod_rdy[s];
          match_data  = prod_data[s*XLEN +: XLEN];
        end
      end
    end

    always_comb begin
      out_data  = rf_data[i*XLEN +: XLEN];
      out_hit   = 1'b0;
      out_stall = 1'b0;
      if (active) begin
        if (match_found) begin
          if (match_rdy) begin
            out_data = match_data;
            out_hit  = 1'b1;
          end else begin
            out_stall = 1'b1;
          end
        end else if (shadow_v && (shadow_rd == addr)) begin
          out_data = shadow_data;
          out_hit  = 1'b1;
        end
        // Only a ready in-pipe producer can supersede an outstanding long-latency write.
        if (pending[addr] && !(match_found && match_rdy)) begin
          out_stall = 1'b1;
        end
      end
    end

    assign fwd_data[i*XLEN +: XLEN] = out_data;
    assign fwd_hit[i]               = out_hit;
    assign src_stall[i]             = out_stall;
  end

  assign hazard_stall = |src_stall;

  // Issue is applied after done so a same-register collision leaves the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (ll_done && (ll_done_rd != '0)) begin
        pending[ll_done_rd] <= 1'b0;
      end
      if (ll_issue && (ll_rd != '0)) begin
        pending[ll_rd] <= 1'b1;
      end
    end
  end

  // Covers the cycle where WB writes the regfile but the read port still returns old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_v    <= 1'b0;
      shadow_rd   <= '0;
      shadow_data <= '0;
    end else if (!stall_in) begin
      if (prod_we[NUM_STG-1] && (prod_rd[(NUM_STG-1)*AW +: AW] != '0)) begin
        shadow_v    <= 1'b1;
        shadow_rd   <= prod_rd[(NUM_STG-1)*AW +: AW];
        shadow_data <= prod_data[(NUM_STG-1)*XLEN +: XLEN];
      end else begin
        shadow_v <= 1'b0;
      end
    end
  end

`ifdef FWD_STALL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (hazard_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: directed scenarios plus randomized
// traffic checked against a behavioural model of bypass priority, shadow and scoreboard.
module tb_fwd_scoreboard_unit;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int NUM_STG = 3;
  localparam int AW      = 5;
  localparam int CNT_W   = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk;
  logic                    rst;
  logic                    stall_in;
  logic [NUM_SRC*AW-1:0]   src_addr;
  logic [NUM_SRC-1:0]      src_used;
  logic [NUM_SRC*XLEN-1:0] rf_data;
  logic [NUM_STG-1:0]      prod_we;
  logic [NUM_STG*AW-1:0]   prod_rd;
  logic [NUM_STG-1:0]      prod_rdy;
  logic [NUM_STG*XLEN-1:0] prod_data;
  logic                    ll_issue;
  logic [AW-1:0]           ll_rd;
  logic                    ll_done;
  logic [AW-1:0]           ll_done_rd;
  logic [NUM_SRC*XLEN-1:0] fwd_data;
  logic [NUM_SRC-1:0]      fwd_hit;
  logic                    hazard_stall;
  logic [CNT_W-1:0]        stall_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fwd_scoreboard_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .AW(AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .src_addr(src_addr), .src_used(src_used), .rf_data(rf_data),
    .prod_we(prod_we), .prod_rd(prod_rd), .prod_rdy(prod_rdy), .prod_data(prod_data),
    .ll_issue(ll_issue), .ll_rd(ll_rd), .ll_done(ll_done), .ll_done_rd(ll_done_rd),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .hazard_stall(hazard_stall),
    .stall_cnt(stall_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];

  bit              m_pend[1<<AW];
  bit              m_sv;
  logic [AW-1:0]   m_srd;
  logic [XLEN-1:0] m_sdata;
  logic [CNT_W-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_sv    = 1'b0;
    m_srd   = '0;
    m_sdata = '0;
    m_cnt   = '0;
  endtask

  // Expected view of one consumer operand from the current inputs and model state.
  task automatic model_src(input int i, output logic [XLEN-1:0] d, output bit h, output bit st);
    logic [AW-1:0] a;
    int first;
    a     = src_addr[i*AW +: AW];
    d     = rf_data[i*XLEN +: XLEN];
    h     = 1'b0;
    st    = 1'b0;
    first = -1;
    if (!src_used[i] || a == 0) return;
    for (int s = 0; s < NUM_STG; s++)
      if (first < 0 && prod_we[s] && prod_rd[s*AW +: AW] == a) first = s;
    if (first >= 0) begin
      if (prod_rdy[first]) begin
        d = prod_data[first*XLEN +: XLEN];
        h = 1'b1;
        return;
      end
      st = 1'b1;
    end else if (m_sv && m_srd == a) begin
      d = m_sdata;
      h = 1'b1;
    end
    if (m_pend[a]) st = 1'b1;
  endtask

  // Check all outputs for the current cycle, advance the model, then cross one clock edge.
  task automatic step();
    logic [XLEN-1:0] d;
    bit h, st, any_st;
    logic [AW-1:0] wb_rd;
    #1;
    any_st = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      model_src(i, d, h, st);
      any_st |= st;
      if (!st) begin
        exp_q.push_back(d);
        check_eq("fwd_data", fwd_data[i*XLEN +: XLEN], exp_q.pop_front());
        check_eq("fwd_hit", fwd_hit[i], h);
      end
    end
    check_eq("hazard_stall", hazard_stall, any_st);
    check_eq("stall_cnt", stall_cnt, m_cnt);
    wb_rd = prod_rd[(NUM_STG-1)*AW +: AW];
    if (!stall_in) begin
      if (prod_we[NUM_STG-1] && wb_rd != 0) begin
        m_sv    = 1'b1;
        m_srd   = wb_rd;
        m_sdata = prod_data[(NUM_STG-1)*XLEN +: XLEN];
      end else begin
        m_sv = 1'b0;
      end
    end
    if (ll_done && ll_done_rd != 0) m_pend[ll_done_rd] = 1'b0;
    if (ll_issue && ll_rd != 0) m_pend[ll_rd] = 1'b1;
`ifdef FWD_STALL_PERF_EN
    if (any_st && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    stall_in   = 1'b0;
    src_addr   = '0;
    src_used   = '0;
    rf_data    = '0;
    prod_we    = '0;
    prod_rd    = '0;
    prod_rdy   = '0;
    prod_data  = '0;
    ll_issue   = 1'b0;
    ll_rd      = '0;
    ll_done    = 1'b0;
    ll_done_rd = '0;
  endtask

  task automatic set_prod(input int s, input bit we, input logic [AW-1:0] rd,
                          input bit rdy, input logic [XLEN-1:0] data);
    prod_we[s]               = we;
    prod_rd[s*AW +: AW]      = rd;
    prod_rdy[s]              = rdy;
    prod_data[s*XLEN +: XLEN] = data;
  endtask

  task automatic set_src(input int i, input bit used, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] rf);
    src_used[i]             = used;
    src_addr[i*AW +: AW]    = a;
    rf_data[i*XLEN +: XLEN] = rf;
  endtask

  // Asynchronous reset in the middle of a cycle; the stall must drop without a clock.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_stall", hazard_stall, 1'b0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drive_random();
    stall_in = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < NUM_SRC; i++)
      set_src(i, ($urandom_range(0, 4) != 0), AW'($urandom_range(0, 7)), $urandom);
    for (int s = 0; s < NUM_STG; s++)
      set_prod(s, $urandom_range(0, 1), AW'($urandom_range(0, 7)),
               ($urandom_range(0, 4) != 0), $urandom);
    ll_issue   = ($urandom_range(0, 6) == 0);
    ll_rd      = AW'($urandom_range(0, 7));
    ll_done    = ($urandom_range(0, 4) == 0);
    ll_done_rd = AW'($urandom_range(0, 7));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_clear();
    idle();
    rst = 1'b0;
    set_src(0, 1'b1, 5'd4, 32'hDEAD_0001);
    set_src(1, 1'b1, 5'd6, 32'hDEAD_0002);
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_hit", fwd_hit, 2'b00);
    check_eq("reset_stall", hazard_stall, 1'b0);
    check_eq("reset_data0", fwd_data[31:0], 32'hDEAD_0001);
    check_eq("reset_data1", fwd_data[63:32], 32'hDEAD_0002);
    check_eq("reset_cnt", stall_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    // youngest matching stage wins
    idle();
    set_prod(0, 1'b1, 5'd5, 1'b1, 32'h11);
    set_prod(2, 1'b1, 5'd5, 1'b1, 32'h22);
    set_src(0, 1'b1, 5'd5, 32'h0);
    #1;
    check_eq("prio_data", fwd_data[31:0], 32'h11);
    check_eq("prio_hit", fwd_hit[0], 1'b1);
    check_eq("prio_stall", hazard_stall, 1'b0);
    step();

    // unready youngest producer blocks older ready ones
    idle();
    set_prod(0, 1'b1, 5'd7, 1'b0, 32'h0);
    set_prod(1, 1'b1, 5'd7, 1'b1, 32'h33);
    set_src(1, 1'b1, 5'd7, 32'h0);
    #1;
    check_eq("load_stall", hazard_stall, 1'b1);
    step();
    idle();
    set_prod(1, 1'b1, 5'd7, 1'b1, 32'h44);
    set_src(1, 1'b1, 5'd7, 32'h0);
    #1;
    check_eq("load_fwd", fwd_data[63:32], 32'h44);
    check_eq("load_stall_off", hazard_stall, 1'b0);
    step();

    // WB shadow lives for exactly one cycle
    idle();
    set_prod(2, 1'b1, 5'd9, 1'b1, 32'hAB);
    step();
    idle();
    set_src(0, 1'b1, 5'd9, 32'h0);
    #1;
    check_eq("shadow_data", fwd_data[31:0], 32'hAB);
    check_eq("shadow_hit", fwd_hit[0], 1'b1);
    step();
    set_src(0, 1'b1, 5'd9, 32'h55);
    #1;
    check_eq("shadow_gone", fwd_data[31:0], 32'h55);
    check_eq("shadow_gone_hit", fwd_hit[0], 1'b0);
    step();

    // long-latency pending register
    do_reset();
    idle();
    ll_issue = 1'b1;
    ll_rd    = 5'd12;
    step();
    idle();
    set_src(0, 1'b1, 5'd12, 32'h77);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        ll_done    = 1'b1;
        ll_done_rd = 5'd12;
      end
      #1;
      check_eq("ll_stall", hazard_stall, 1'b1);
      step();
    end
    ll_done = 1'b0;
    #1;
    check_eq("ll_released", hazard_stall, 1'b0);
    check_eq("ll_data", fwd_data[31:0], 32'h77);
`ifdef FWD_STALL_PERF_EN
    check_eq("ll_cnt", stall_cnt, 4);
`else
    check_eq("ll_cnt", stall_cnt, 0);
`endif
    step();

    // same-cycle issue and done: set wins
    idle();
    ll_issue = 1'b1; ll_rd = 5'd3;
    ll_done  = 1'b1; ll_done_rd = 5'd3;
    step();
    idle();
    set_src(1, 1'b1, 5'd3, 32'h0);
    #1;
    check_eq("set_wins", hazard_stall, 1'b1);
    ll_done = 1'b1; ll_done_rd = 5'd3;
    step();

    // x0 is never forwarded
    idle();
    set_prod(0, 1'b1, 5'd0, 1'b1, 32'hFFFF);
    set_src(0, 1'b1, 5'd0, 32'h0);
    #1;
    check_eq("x0_hit", fwd_hit[0], 1'b0);
    check_eq("x0_data", fwd_data[31:0], 32'h0);
    check_eq("x0_stall", hazard_stall, 1'b0);
    step();

    // reset with live pending bit and shadow
    idle();
    ll_issue = 1'b1; ll_rd = 5'd12;
    step();
    idle();
    set_prod(2, 1'b1, 5'd9, 1'b1, 32'hCD);
    step();
    idle();
    set_src(0, 1'b1, 5'd12, 32'h99);
    #1;
    check_eq("pre_rst_stall", hazard_stall, 1'b1);
    do_reset();
    set_src(1, 1'b1, 5'd9, 32'h88);
    #1;
    check_eq("post_rst_data", fwd_data[31:0], 32'h99);
    check_eq("post_rst_shadow", fwd_data[63:32], 32'h88);
    step();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive_random();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
